// File: rtl/room_pkg.sv
// rtl/room_pkg.sv - shared door codes, state encoding and map helpers for the room controller
package room_pkg;

   // Map geometry: 4 columns by 2 rows, room = row*4 + col
   localparam int MAP_COLS = 4;
   localparam int MAP_ROWS = 2;

   // Door-crossing codes reported by the player stage
   localparam logic [2:0] DOOR_NONE  = 3'd0;
   localparam logic [2:0] DOOR_RIGHT = 3'd1;
   localparam logic [2:0] DOOR_LEFT  = 3'd2;
   localparam logic [2:0] DOOR_UP    = 3'd3;
   localparam logic [2:0] DOOR_DOWN  = 3'd4;

   // Controller states
   typedef enum logic {
      IDLE  = 1'b0,
      BLANK = 1'b1
   } state_t;

   // Column of a room index
   function automatic logic [1:0] room_col(input logic [2:0] r);
      return r[1:0];
   endfunction

   // Row of a room index
   function automatic logic room_row(input logic [2:0] r);
      return r[2];
   endfunction

   // Compose a room index from row and column
   function automatic logic [2:0] make_room(input logic row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/room_neighbor.sv
// rtl/room_neighbor.sv - combinational neighbour lookup on the wrapping 4x2 room map
module room_neighbor
   import room_pkg::*;
(
   input  logic [2:0] room,
   input  logic [2:0] doorcode,
   output logic [2:0] next_room,
   output logic       valid
);

   logic [1:0] col;
   logic       row;
   logic [1:0] col_right;
   logic [1:0] col_left;

   // Split the index and precompute the wrapped column moves
   always_comb begin
      col       = room_col(room);
      row       = room_row(room);
      col_right = col + 2'd1;
      col_left  = col - 2'd1;
   end

   // Every move wraps, so any recognised door code yields a valid neighbour
   always_comb begin
      next_room = room;
      valid     = 1'b0;
      case (doorcode)
         DOOR_RIGHT: begin
            next_room = make_room(row, col_right);
            valid     = 1'b1;
         end
         DOOR_LEFT: begin
            next_room = make_room(row, col_left);
            valid     = 1'b1;
         end
         DOOR_UP, DOOR_DOWN: begin
            next_room = make_room(~row, col);
            valid     = 1'b1;
         end
         default: begin
            next_room = room;
            valid     = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/room_controller.sv
// rtl/room_controller.sv - tracks the current room and blanks the screen across room changes
module room_controller
   import room_pkg::*;
#(
   parameter int unsigned START_ROOM   = 0,
   parameter int unsigned BLANK_FRAMES = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [2:0] doorcode,
   output logic [2:0] room,
   output logic       blank,
   output logic       room_changed,
   output logic [7:0] visited
);

   localparam logic [2:0] START_IDX   = 3'(START_ROOM);
   localparam logic [3:0] BLANK_RELOAD = 4'(BLANK_FRAMES - 1);

   state_t     state;
   state_t     state_n;
   logic [3:0] count;
   logic [3:0] count_n;
   logic       frame_clk_delayed;
   logic [2:0] room_n;
   logic       room_changed_n;
   logic [7:0] visited_n;
   logic       blank_n;
   logic       tick;

   logic [2:0] nb_room;
   logic       nb_valid;

   room_neighbor u_neighbor (
      .room      (room),
      .doorcode  (doorcode),
      .next_room (nb_room),
      .valid     (nb_valid)
   );

   // State register; reset wins over any tick in the same cycle
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state             <= IDLE;
         count             <= 4'd0;
         frame_clk_delayed <= 1'b0;
         room              <= START_IDX;
         room_changed      <= 1'b0;
         blank             <= 1'b0;
         visited           <= 8'b1 << START_IDX;
      end else begin
         state             <= state_n;
         count             <= count_n;
         frame_clk_delayed <= frame_clk;
         room              <= room_n;
         room_changed      <= room_changed_n;
         blank             <= blank_n;
         visited           <= visited_n;
      end
   end

   // Frame-edge detection, door handling and blanking countdown
   always_comb begin
      tick           = frame_clk & ~frame_clk_delayed;
      state_n        = state;
      count_n        = count;
      room_n         = room;
      room_changed_n = 1'b0;
      visited_n      = visited;
      case (state)
         IDLE: begin
            // Doorcode is looked at only on the frame edge so one crossing moves once
            if (tick && nb_valid) begin
               room_n         = nb_room;
               room_changed_n = 1'b1;
               visited_n      = visited | (8'b1 << nb_room);
               count_n        = BLANK_RELOAD;
               state_n        = BLANK;
            end
         end
         BLANK: begin
            // Doors are ignored here, including on the exiting tick
            if (tick) begin
               if (count != 4'd0) begin
                  count_n = count - 4'd1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      blank_n = (state_n == BLANK);
   end

endmodule

// File: tb/tb_room_controller.sv
// tb/tb_room_controller.sv - scoreboard bench for room_controller
module tb_room_controller;

   localparam int BLANK_N = 8;

   logic       Clk;
   logic       Reset;
   logic       frame_clk;
   logic [2:0] doorcode;
   logic [2:0] room;
   logic       blank;
   logic       room_changed;
   logic [7:0] visited;

   typedef struct packed {
      logic [2:0] room;
      logic       rc;
      logic       blank;
      logic [7:0] visited;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   // Reference model state
   int         m_room;
   int         m_count;
   logic       m_blank;
   logic [7:0] m_visited;

   room_controller #(
      .START_ROOM   (0),
      .BLANK_FRAMES (BLANK_N)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .doorcode     (doorcode),
      .room         (room),
      .blank        (blank),
      .room_changed (room_changed),
      .visited      (visited)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Map arithmetic written out as row/column math
   function automatic int model_nbr(input int r, input int code);
      int col, row;
      col = r % 4;
      row = r / 4;
      case (code)
         1: return row * 4 + (col + 1) % 4;
         2: return row * 4 + (col + 3) % 4;
         3, 4: return (1 - row) * 4 + col;
         default: return r;
      endcase
   endfunction

   function automatic exp_t model_tick(input int code);
      exp_t e;
      logic rc;
      rc = 1'b0;
      if (m_blank) begin
         if (m_count != 0) m_count--;
         else m_blank = 1'b0;
      end else if (code >= 1 && code <= 4) begin
         m_room    = model_nbr(m_room, code);
         m_visited = m_visited | (8'b1 << m_room);
         m_count   = BLANK_N - 1;
         m_blank   = 1'b1;
         rc        = 1'b1;
      end
      e.room    = 3'(m_room);
      e.rc      = rc;
      e.blank   = m_blank;
      e.visited = m_visited;
      return e;
   endfunction

   task automatic compare_pop(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_room"},    32'(room),         32'(e.room));
      chk({tag, "_rc"},      32'(room_changed), 32'(e.rc));
      chk({tag, "_blank"},   32'(blank),        32'(e.blank));
      chk({tag, "_visited"}, 32'(visited),      32'(e.visited));
   endtask

   // One frame strobe: high for hi cycles, then low for two
   task automatic frame(input int code, input int hi);
      @(negedge Clk);
      doorcode  = 3'(code);
      frame_clk = 1'b1;
      sb.push_back(model_tick(code));
      @(negedge Clk);
      compare_pop("tick");
      for (int i = 1; i < hi; i++) begin
         @(negedge Clk);
         chk("hold_rc",    32'(room_changed), 0);
         chk("hold_room",  32'(room),         32'(m_room));
         chk("hold_blank", 32'(blank),        32'(m_blank));
      end
      @(negedge Clk);
      frame_clk = 1'b0;
      doorcode  = 3'd0;
      @(negedge Clk);
      chk("low_rc", 32'(room_changed), 0);
   endtask

   // Take a door and let the blanking run out with idle frames
   task automatic move(input int code);
      frame(code, 2);
      for (int i = 0; i < BLANK_N; i++) frame(0, 1);
   endtask

   initial begin
      Reset     = 1'b1;
      frame_clk = 1'b0;
      doorcode  = 3'd0;
      m_room    = 0;
      m_count   = 0;
      m_blank   = 1'b0;
      m_visited = 8'h01;
      repeat (3) @(negedge Clk);
      chk("rst_room",    32'(room),         0);
      chk("rst_blank",   32'(blank),        0);
      chk("rst_rc",      32'(room_changed), 0);
      chk("rst_visited", 32'(visited),      32'h01);
      Reset = 1'b0;

      // First move, then doors hammered during blanking are ignored
      frame(1, 2);
      chk("first_room",    32'(room),    1);
      chk("first_visited", 32'(visited), 32'h03);
      for (int i = 0; i < BLANK_N; i++) frame(1, 1);
      chk("blank_done", 32'(blank), 0);
      chk("still_room1", 32'(room), 1);

      // Accepted again once idle
      move(1);
      chk("room2", 32'(room), 2);
      move(3);
      chk("room6", 32'(room), 6);
      move(4);
      chk("room2b", 32'(room), 2);
      move(1);
      chk("room3", 32'(room), 3);
      move(1);
      chk("wrap_right", 32'(room), 0);
      move(2);
      chk("wrap_left", 32'(room), 3);

      // Invalid codes in IDLE change nothing
      for (int c = 5; c <= 7; c++) frame(c, 1);
      frame(0, 1);
      chk("invalid_room", 32'(room), 3);

      // Long strobe gives only one tick
      frame(1, 100);
      for (int i = 0; i < BLANK_N - 1; i++) frame(0, 1);
      chk("long_still_blank", 32'(blank), 1);
      frame(0, 1);
      chk("long_blank_off", 32'(blank), 0);
      chk("long_room", 32'(room), 0);

      // Walk to room 5, then reset on the third blanking tick
      move(3);
      move(1);
      chk("room5", 32'(room), 5);
      // Wait, we are in 5 idle now; re-enter 5 from 4 so blanking is fresh
      move(2);
      frame(1, 2);
      chk("room5b", 32'(room), 5);
      frame(0, 1);
      frame(0, 1);
      @(negedge Clk);
      Reset     = 1'b1;
      frame_clk = 1'b1;
      doorcode  = 3'd1;
      m_room    = 0;
      m_count   = 0;
      m_blank   = 1'b0;
      m_visited = 8'h01;
      sb.push_back('{room: 3'd0, rc: 1'b0, blank: 1'b0, visited: 8'h01});
      @(negedge Clk);
      compare_pop("reset_mid");
      Reset     = 1'b0;
      frame_clk = 1'b0;
      doorcode  = 3'd0;
      @(negedge Clk);

      move(1);
      chk("post_reset_room",    32'(room),    1);
      chk("post_reset_visited", 32'(visited), 32'h03);
      chk("sb_drained", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/room_controller.md
ROOM_CONTROLLER -- requirements
Module: room_controller

Interface
REQ-001 Parameter START_ROOM, default 0: room index after reset, range 0..7.
REQ-002 Parameter BLANK_FRAMES, default 8: frame periods the screen is blanked per room change, range 1..15.
REQ-003 Clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 frame_clk  input  1  vertical-sync-rate frame strobe, synchronous to Clk, level signal.
REQ-006 doorcode  input  3  door-crossing code from the player stage: 0 none, 1 right, 2 left, 3 up, 4 down, 5..7 invalid.
REQ-007 room  output  3  current room index, registered; fed back to the player stage and level ROM.
REQ-008 blank  output  1  high while a room transition is in progress; the renderer forces black.
REQ-009 room_changed  output  1  single-Clk pulse on the cycle room takes a new value.
REQ-010 visited  output  8  bit i set once room i has been entered, for the minimap.

Function
REQ-011 Frame tick: a registered copy of frame_clk SHALL be kept, and tick = frame_clk & ~frame_clk_delayed.
REQ-012 doorcode SHALL be sampled only on tick cycles; the pre-edge value is used, so each player door event is seen exactly once.
REQ-013 Map: 4 columns x 2 rows, room = row*4 + col, col = room[1:0], row = room[2].
REQ-014 Right: col+1 mod 4. Left: col-1 mod 4. Up and down both toggle row. All moves wrap and no move is blocked.
REQ-015 States: IDLE and BLANK.
REQ-016 IDLE, tick, doorcode 1..4: room <= neighbour; room_changed=1 for that cycle; visited[neighbour] <= 1; count <= BLANK_FRAMES-1; next state BLANK.
REQ-017 IDLE, tick, doorcode 0 or 5..7: no change.
REQ-018 BLANK, tick, count != 0: count <= count-1.
REQ-019 BLANK, tick, count == 0: next state IDLE.
REQ-020 All doorcodes sampled while in BLANK, including on the exiting tick, SHALL be ignored.
REQ-021 blank SHALL equal (state == BLANK) and be registered, not decoded from doorcode.
REQ-022 blank SHALL be high for exactly BLANK_FRAMES tick intervals: it rises in the cycle after the entering tick and falls in the cycle after the exiting tick.
REQ-023 Latency: room, room_changed and blank all update 1 Clk after the tick cycle.
REQ-024 count is 4 bits, unsigned, and never underflows.
REQ-025 room_changed SHALL never be asserted on two consecutive cycles.
REQ-026 Between room changes, room_changed SHALL stay low.

Reset
REQ-027 Reset SHALL set: room=START_ROOM, state=IDLE, blank=0, room_changed=0, count=0, visited=(1<<START_ROOM), frame_clk_delayed=0.
REQ-028 Reset SHALL take priority over a simultaneous tick.
REQ-029 Reset asserted mid-BLANK SHALL abort the transition and return to IDLE at START_ROOM on the next cycle.

Structure
REQ-030 Package room_pkg SHALL hold:
- door code constants DOOR_NONE/RIGHT/LEFT/UP/DOWN;
- state enum (IDLE, BLANK);
- MAP_COLS=4, MAP_ROWS=2.
REQ-031 Sub-module room_neighbor SHALL be purely combinational: (room, doorcode) -> (next_room, valid), reused by the bench model.
REQ-032 All remaining logic SHALL be a single always_ff plus a single always_comb in room_controller.

Verification
REQ-033 Start room 0, doorcode=1 at tick -> room=1, room_changed pulse, visited=8'h03, blank high for 8 ticks.
REQ-034 Room 3, doorcode=1 -> room 0 (column wrap). Room 0, doorcode=2 -> room 3. Room 2, doorcode=3 -> room 6. Room 6, doorcode=4 -> room 2.
REQ-035 During BLANK, doorcode=1 at every tick -> room unchanged and no room_changed pulse. After blank falls, the next doorcode=1 is accepted.
REQ-036 doorcode=5, 6 or 7 at tick in IDLE -> no change to any output.
REQ-037 Reset asserted at the 3rd tick of BLANK in room 5 -> next cycle room=0, blank=0, visited=8'h01.
REQ-038 frame_clk held high for 100 Clk -> only one tick: at most one transition and a single count decrement.
